// File: rtl/fetch_decode_queue_if.sv
// Handshake bundle between Fetch, the instruction queue and Decode.
// The queue takes the slave view; whatever drives Fetch/Decode takes the master view.
interface fetch_decode_queue_if #(
    parameter int PC_WIDTH          = 32,
    parameter int INSTRUCTION_WIDTH = 30,
    parameter int DEPTH             = 2
);
    logic                         flush;
    logic                         in_valid;
    logic [PC_WIDTH-1:0]          in_pc;
    logic [INSTRUCTION_WIDTH-1:0] in_instr;
    logic                         fetch_ready;
    logic                         out_valid;
    logic [PC_WIDTH-1:0]          out_pc;
    logic [INSTRUCTION_WIDTH-1:0] out_instr;
    logic                         decode_ready;
    logic [$clog2(DEPTH):0]       count;

    modport master (
        output flush, in_valid, in_pc, in_instr, decode_ready,
        input  fetch_ready, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, decode_ready,
        output fetch_ready, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// Circular FIFO of (PC, instruction) pairs between Fetch and Decode.
// Every output is decoded from registered state only, so in_* never reaches out_* in the same cycle.
module fetch_decode_queue #(
    parameter int PC_WIDTH          = 32,
    parameter int INSTRUCTION_WIDTH = 30,
    parameter int DEPTH             = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    fetch_decode_queue_if.slave   q
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = PC_WIDTH + INSTRUCTION_WIDTH;

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic [ENTRY_W-1:0] head_s;

    // Occupancy flags and transfer qualification; flush suppresses both transfers.
    always_comb begin
        full_s  = (count_r == CNT_W'(DEPTH));
        empty_s = (count_r == {CNT_W{1'b0}});
        push_s  = q.in_valid & ~full_s & ~q.flush;
        pop_s   = ~empty_s & q.decode_ready & ~q.flush;
        head_s  = mem_r[rd_ptr_r];
    end

    // Entry storage carries no reset: contents are only observed while counted as occupied.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {q.in_pc, q.in_instr};
        end
    end

    // Pointers and occupancy; DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (q.flush) begin
            rd_ptr_r <= wr_ptr_r;
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head presentation; payload is zeroed while empty so Decode never sees stale data.
    always_comb begin
        q.fetch_ready = ~full_s;
        q.out_valid   = ~empty_s;
        q.count       = count_r;
        if (!empty_s) begin
            q.out_pc    = head_s[ENTRY_W-1:INSTRUCTION_WIDTH];
            q.out_instr = head_s[INSTRUCTION_WIDTH-1:0];
        end else begin
            q.out_pc    = {PC_WIDTH{1'b0}};
            q.out_instr = {INSTRUCTION_WIDTH{1'b0}};
        end
    end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench: directed stimulus for a DEPTH=2 and a DEPTH=4 queue, with a
// negedge monitor that compares every DUT output against an expected-entry queue.
module tb_fetch_decode_queue;
    typedef struct packed {
        logic [31:0] pc;
        logic [29:0] instr;
    } pair_t;

    logic  clock = 1'b0;
    logic  reset = 1'b1;
    int    checks = 0;
    int    errors = 0;
    pair_t exp_q   [2][$];
    int    pop_log [2][$];

    fetch_decode_queue_if #(.PC_WIDTH(32), .INSTRUCTION_WIDTH(30), .DEPTH(2)) q2 ();
    fetch_decode_queue_if #(.PC_WIDTH(32), .INSTRUCTION_WIDTH(30), .DEPTH(4)) q4 ();

    fetch_decode_queue #(.PC_WIDTH(32), .INSTRUCTION_WIDTH(30), .DEPTH(2)) u_dut2 (
        .clock (clock),
        .reset (reset),
        .q     (q2.slave)
    );

    fetch_decode_queue #(.PC_WIDTH(32), .INSTRUCTION_WIDTH(30), .DEPTH(4)) u_dut4 (
        .clock (clock),
        .reset (reset),
        .q     (q4.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h", nm, d, act, exp);
        end
    endtask

    // Compare one DUT against the expected queue, then advance the queue by the transfer about to happen.
    task automatic step(input int d, input int depth, input logic rs, input logic fl, input logic iv,
                        input logic [31:0] ipc, input logic [29:0] ii, input logic dr, input int cnt,
                        input logic fr, input logic ov, input logic [31:0] opc, input logic [29:0] oi);
        int n;
        if (rs) exp_q[d].delete();
        n = exp_q[d].size();
        chk("count", d, 64'(cnt), 64'(n));
        chk("out_valid", d, 64'(ov), 64'(n != 0));
        chk("fetch_ready", d, 64'(fr), 64'(n != depth));
        if (n != 0) begin
            chk("out_pc", d, 64'(opc), 64'(exp_q[d][0].pc));
            chk("out_instr", d, 64'(oi), 64'(exp_q[d][0].instr));
        end else begin
            chk("out_pc_empty", d, 64'(opc), 64'd0);
            chk("out_instr_empty", d, 64'(oi), 64'd0);
        end
        if (!rs) begin
            if (fl) begin
                exp_q[d].delete();
            end else begin
                if (n != 0 && dr) begin
                    pop_log[d].push_back(int'(opc));
                    void'(exp_q[d].pop_front());
                end
                if (iv && n != depth) exp_q[d].push_back('{pc: ipc, instr: ii});
            end
        end
    endtask

    always @(negedge clock) begin
        step(0, 2, reset, q2.flush, q2.in_valid, q2.in_pc, q2.in_instr, q2.decode_ready,
             int'(q2.count), q2.fetch_ready, q2.out_valid, q2.out_pc, q2.out_instr);
        step(1, 4, reset, q4.flush, q4.in_valid, q4.in_pc, q4.in_instr, q4.decode_ready,
             int'(q4.count), q4.fetch_ready, q4.out_valid, q4.out_pc, q4.out_instr);
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_log(input int d, input string nm, input int first, input int n);
        chk({nm, "_len"}, d, 64'(pop_log[d].size()), 64'(n));
        for (int i = 0; i < n && i < pop_log[d].size(); i++) begin
            chk(nm, d, 64'(pop_log[d][i]), 64'(first + i));
        end
        pop_log[d].delete();
    endtask

    task automatic push2(input int pc);
        q2.in_valid = 1'b1;
        q2.in_pc    = 32'(pc);
        q2.in_instr = 30'(pc * 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog dut0 actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int c;
        logic acc;
        q2.flush = 1'b0; q2.in_valid = 1'b0; q2.in_pc = 32'd0; q2.in_instr = 30'd0; q2.decode_ready = 1'b0;
        q4.flush = 1'b0; q4.in_valid = 1'b0; q4.in_pc = 32'd0; q4.in_instr = 30'd0; q4.decode_ready = 1'b0;
        #3;
        chk("rst_count", 0, 64'(q2.count), 64'd0);
        chk("rst_fetch_ready", 0, 64'(q2.fetch_ready), 64'd1);
        cyc();
        cyc();
        reset = 1'b0;

        // 1: reset in the middle of a stream
        push2(1); cyc();
        push2(2); cyc();
        q2.in_valid = 1'b0;
        chk("t1_full_count", 0, 64'(q2.count), 64'd2);
        #2 reset = 1'b1;
        #1;
        chk("t1_count", 0, 64'(q2.count), 64'd0);
        chk("t1_out_valid", 0, 64'(q2.out_valid), 64'd0);
        chk("t1_out_pc", 0, 64'(q2.out_pc), 64'd0);
        chk("t1_fetch_ready", 0, 64'(q2.fetch_ready), 64'd1);
        cyc();
        reset = 1'b0;
        pop_log[0].delete();

        // 2: streaming with Decode always ready
        q2.decode_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push2(i);
            cyc();
            chk("t2_count", 0, 64'(q2.count), 64'd1);
            chk("t2_head", 0, 64'(q2.out_pc), 64'(i));
        end
        q2.in_valid = 1'b0;
        cyc(); cyc();
        chk_log(0, "t2_order", 0, 6);

        // 3 and 4: Decode stall, then full queue with simultaneous push attempt and pop
        q2.decode_ready = 1'b0;
        push2(10); cyc();
        push2(11); cyc();
        push2(12);
        chk("t3_count", 0, 64'(q2.count), 64'd2);
        chk("t3_fetch_ready", 0, 64'(q2.fetch_ready), 64'd0);
        cyc(); cyc();
        chk("t3_held_head", 0, 64'(q2.out_pc), 64'd10);
        q2.decode_ready = 1'b1;
        cyc();
        chk("t4_count", 0, 64'(q2.count), 64'd1);
        chk("t4_head", 0, 64'(q2.out_pc), 64'd11);
        cyc();
        q2.in_valid = 1'b0;
        cyc(); cyc();
        chk_log(0, "t3_order", 10, 3);

        // 5: flush discards queued entries and the same-cycle push
        q2.decode_ready = 1'b0;
        push2(20); cyc();
        push2(21); cyc();
        push2(22);
        q2.flush = 1'b1;
        cyc();
        q2.flush = 1'b0;
        q2.in_valid = 1'b0;
        chk("t5_count", 0, 64'(q2.count), 64'd0);
        chk("t5_out_valid", 0, 64'(q2.out_valid), 64'd0);
        chk("t5_fetch_ready", 0, 64'(q2.fetch_ready), 64'd1);
        push2(40);
        q2.decode_ready = 1'b1;
        cyc();
        q2.in_valid = 1'b0;
        chk("t5_target_pc", 0, 64'(q2.out_pc), 64'd40);
        chk("t5_target_instr", 0, 64'(q2.out_instr), 64'd120);
        cyc(); cyc();
        chk_log(0, "t5_order", 40, 1);

        // 6: DEPTH=4 with mixed stalls, nine entries wrap the pointers twice
        k = 0;
        c = 0;
        pop_log[1].delete();
        while (pop_log[1].size() < 9 && c < 60) begin
            q4.in_valid     = (k < 9) && !(c == 7 || c == 12);
            q4.in_pc        = 32'(100 + k);
            q4.in_instr     = 30'((100 + k) * 5);
            q4.decode_ready = !(c < 6 || (c >= 9 && c < 12));
            @(negedge clock);
            acc = q4.in_valid && q4.fetch_ready;
            cyc();
            if (acc) k++;
            c++;
        end
        q4.in_valid = 1'b0;
        chk("t6_done", 1, 64'(pop_log[1].size()), 64'd9);
        chk_log(1, "t6_order", 100, 9);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
